// File: rtl/bsg_and_fold_stream_pkg.sv
// ---------------------------------------------------------------------------
// bsg_and_fold_stream_pkg
//   Shared types and helpers for the bsg_and_fold_stream block.
//   - bsg_and_fold_state_e : FSM encoding (eACCUM collects words, eDONE
//                            presents the folded mask)
//   - ctr_width()          : group counter width, max(1, $clog2(els))
// ---------------------------------------------------------------------------
package bsg_and_fold_stream_pkg;

  typedef enum logic [0:0] {
    eACCUM = 1'b0,
    eDONE  = 1'b1
  } bsg_and_fold_state_e;

  // A group of one word still needs a 1-bit counter so the port exists.
  function automatic int ctr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/bsg_and_fold_stream_ctr.sv
// ---------------------------------------------------------------------------
// bsg_and_fold_stream_ctr
//   Up-counter over the words of one group. Counts 0..els_p-1 and clears
//   when it advances from the terminal value.
// Ports:
//   clk_i    : clock
//   reset_i  : asynchronous, active-high reset (count -> 0)
//   en_i     : advance the count (one accepted word)
//   cnt_r    : current count
//   last_o   : cnt_r == els_p-1 (next advance completes the group)
// ---------------------------------------------------------------------------
module bsg_and_fold_stream_ctr
  import bsg_and_fold_stream_pkg::*;
#(
  parameter int els_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           en_i,
  output logic [ctr_width(els_p)-1:0]    cnt_r,
  output logic                           last_o
);

  localparam int                    cnt_w_lp = ctr_width(els_p);
  localparam logic [cnt_w_lp-1:0]   term_lp  = cnt_w_lp'(els_p - 1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (en_i) begin
      // Clearing at the terminal value keeps the count inside 0..els_p-1
      // even when els_p is not a power of two.
      cnt_r <= last_o ? '0 : cnt_r + cnt_w_lp'(1);
    end
  end

  assign last_o = (cnt_r == term_lp);

endmodule

// File: rtl/bsg_and_fold_stream.sv
// ---------------------------------------------------------------------------
// bsg_and_fold_stream
//   Folds each group of els_p consecutive input words into one bitwise-AND
//   mask and presents it on a valid/yumi output.
//
// Handshakes:
//   Input  : a word transfers on a rising edge where v_i & ready_o.
//            ready_o is a pure function of the state register; it never
//            depends combinationally on yumi_i or v_i.
//   Output : data_o is valid while v_o=1 and is held stable until the
//            consumer asserts yumi_i (legal only while v_o=1); the result
//            is released on that rising edge.
//
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   v_i, data_i     : input word stream
//   mask_i          : per-bit word mask (only with BSG_AND_FOLD_STREAM_MASK_EN)
//   ready_o         : block can accept a word this cycle
//   v_o, data_o     : folded AND result (data_o mirrors the accumulator)
//   yumi_i          : consumer takes the result
//   last_o          : next accepted word completes the group
//   dbg_state_o     : FSM state (eACCUM / eDONE)
//   dbg_cnt_o       : words accepted so far in the current group
//
// Build option:
//   BSG_AND_FOLD_STREAM_MASK_EN adds mask_i; bits with mask_i=0 are folded
//   as 1 (don't-care), i.e. the effective word is data_i | ~mask_i.
// ---------------------------------------------------------------------------
module bsg_and_fold_stream
  import bsg_and_fold_stream_pkg::*;
#(
  parameter int width_p = 16,
  parameter int els_p   = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
`ifdef BSG_AND_FOLD_STREAM_MASK_EN
  input  logic [width_p-1:0]           mask_i,
`endif
  output logic                         ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic                         last_o,
  output logic [0:0]                   dbg_state_o,
  output logic [ctr_width(els_p)-1:0]  dbg_cnt_o
);

  localparam int cnt_w_lp = ctr_width(els_p);

  bsg_and_fold_state_e   state_r;
  logic [width_p-1:0]    acc_r;

  logic                  w_accept;
  logic [width_p-1:0]    w_word;
  logic [cnt_w_lp-1:0]   w_cnt;
  logic                  w_last;

`ifdef BSG_AND_FOLD_STREAM_MASK_EN
  assign w_word = data_i | ~mask_i;
`else
  assign w_word = data_i;
`endif

  // Words offered while in eDONE are ignored, whatever their contents.
  assign w_accept = v_i & (state_r == eACCUM);

  bsg_and_fold_stream_ctr #(
    .els_p (els_p)
  ) u_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (w_accept),
    .cnt_r   (w_cnt),
    .last_o  (w_last)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= eACCUM;
      acc_r   <= '0;
    end else begin
      case (state_r)
        eACCUM: begin
          if (w_accept) begin
            // The first word of a group overwrites the previous result
            // instead of being ANDed into it.
            acc_r <= (w_cnt == '0) ? w_word : (acc_r & w_word);
            if (w_last) begin
              state_r <= eDONE;
            end
          end
        end
        eDONE: begin
          if (yumi_i) begin
            state_r <= eACCUM;
          end
        end
        default: begin
          state_r <= eACCUM;
        end
      endcase
    end
  end

  assign ready_o     = (state_r == eACCUM);
  assign v_o         = (state_r == eDONE);
  assign data_o      = acc_r;
  assign last_o      = w_last;
  assign dbg_state_o = state_r;
  assign dbg_cnt_o   = w_cnt;

`ifdef SIMULATION
  // Taking a result that is not being offered is a consumer bug.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o));
    end
  end
`endif

endmodule

// File: tb/tb_bsg_and_fold_stream.sv
module tb_bsg_and_fold_stream;

  // ------------------------------------------------------------------
  // clock / reset
  // ------------------------------------------------------------------
  logic clk;
  logic reset_i;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------
  // DUT 0: width 16, els 4
  // ------------------------------------------------------------------
  logic        v_i;
  logic [15:0] data_i;
  logic [15:0] mask_i;
  logic        ready_o;
  logic        v_o;
  logic [15:0] data_o;
  logic        yumi_i;
  logic        last_o;
  logic [0:0]  dbg_state_o;
  logic [1:0]  dbg_cnt_o;

  bsg_and_fold_stream #(.width_p(16), .els_p(4)) u_dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .data_i      (data_i),
`ifdef BSG_AND_FOLD_STREAM_MASK_EN
    .mask_i      (mask_i),
`endif
    .ready_o     (ready_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi_i),
    .last_o      (last_o),
    .dbg_state_o (dbg_state_o),
    .dbg_cnt_o   (dbg_cnt_o)
  );

  // ------------------------------------------------------------------
  // DUT 1: width 8, els 1
  // ------------------------------------------------------------------
  logic       v1_i;
  logic [7:0] d1_i;
  logic [7:0] m1_i;
  logic       ready1_o;
  logic       v1_o;
  logic [7:0] d1_o;
  logic       yumi1_i;
  logic       last1_o;
  logic [0:0] st1_o;
  logic [0:0] cnt1_o;

  bsg_and_fold_stream #(.width_p(8), .els_p(1)) u_dut1 (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .v_i         (v1_i),
    .data_i      (d1_i),
`ifdef BSG_AND_FOLD_STREAM_MASK_EN
    .mask_i      (m1_i),
`endif
    .ready_o     (ready1_o),
    .v_o         (v1_o),
    .data_o      (d1_o),
    .yumi_i      (yumi1_i),
    .last_o      (last1_o),
    .dbg_state_o (st1_o),
    .dbg_cnt_o   (cnt1_o)
  );

  // ------------------------------------------------------------------
  // bookkeeping
  // ------------------------------------------------------------------
  int tests_run    = 0;
  int tests_failed = 0;
  int cnt_viol     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // scoreboard: model folds accepted words, pushes expected mask per group
  // ------------------------------------------------------------------
  logic [15:0] exp_q[$];
  logic [15:0] acc_m;
  int          cnt_m;
  logic [15:0] last_out;

  function automatic logic [15:0] eff_word(input logic [15:0] d, input logic [15:0] m);
`ifdef BSG_AND_FOLD_STREAM_MASK_EN
    return d | ~m;
`else
    return d | (m & 16'h0000);
`endif
  endfunction

  initial begin
    acc_m    = '0;
    cnt_m    = 0;
    last_out = '0;
    forever begin
      @(negedge clk or posedge reset_i);
      if (reset_i) begin
        cnt_m = 0;
        exp_q.delete();
      end else begin
        if (dbg_cnt_o !== 2'(cnt_m) || dbg_cnt_o > 2'd3) cnt_viol++;
        if (v_o && yumi_i) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb_unexpected: got %h expected none", data_o);
          end else begin
            chk("sb_data", {16'h0, data_o}, {16'h0, exp_q.pop_front()});
          end
          last_out = data_o;
        end
        if (v_i && ready_o) begin
          if (cnt_m == 0) acc_m = eff_word(data_i, mask_i);
          else            acc_m = acc_m & eff_word(data_i, mask_i);
          cnt_m++;
          if (cnt_m == 4) begin
            exp_q.push_back(acc_m);
            cnt_m = 0;
          end
        end
      end
    end
  end

  // consumer: 0 = never take, 1 = take immediately, 2 = take randomly
  int yumi_mode = 1;

  initial begin
    yumi_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (yumi_mode)
        0:       yumi_i = 1'b0;
        1:       yumi_i = v_o;
        default: yumi_i = v_o && ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // ------------------------------------------------------------------
  // driver tasks (called at posedge+1)
  // ------------------------------------------------------------------
  task automatic send_word(input logic [15:0] d, input logic [15:0] m);
    int n = 0;
    v_i    = 1'b1;
    data_i = d;
    mask_i = m;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: got ready_o=0 expected 1");
    end
    @(posedge clk);
    #1;
    v_i    = 1'b0;
    data_i = 16'($urandom);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || v_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------
  // vector table
  // ------------------------------------------------------------------
  typedef struct packed {
    logic [3:0][15:0] w;
    logic [15:0]      exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{w: {16'hFF00, 16'h3C3C, 16'hF0F0, 16'hFFFF}, exp: 16'h3000};
    tbl[1] = '{w: {16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA}, exp: 16'hAAAA};
    tbl[2] = '{w: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234}, exp: 16'h1234};
    tbl[3] = '{w: {16'h0001, 16'h0003, 16'h0007, 16'h000F}, exp: 16'h0001};
    tbl[4] = '{w: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, exp: 16'hFFFF};
    tbl[5] = '{w: {16'hF00F, 16'hE007, 16'hC003, 16'h8001}, exp: 16'h8001};
    tbl[6] = '{w: {16'h0FF0, 16'hFFFF, 16'h00FF, 16'h0F0F}, exp: 16'h0000};

    v_i = 0; data_i = '0; mask_i = 16'hFFFF;
    v1_i = 0; d1_i = '0; m1_i = 8'hFF; yumi1_i = 0;

    // ---------------- reset state
    reset_i = 1'b1;
    #3;
    chk("rst_ready", ready_o, 1);
    chk("rst_v", v_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_state", dbg_state_o, 0);
    chk("rst_cnt", dbg_cnt_o, 0);
    chk("rst1_last", last1_o, 1);
    chk("rst1_ready", ready1_o, 1);
    #9;
    reset_i = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- back-to-back group, exact latency and bubble
    yumi_mode = 1;
    v_i = 1; mask_i = 16'hFFFF;
    data_i = 16'hFFFF; @(posedge clk); #1;
    data_i = 16'hF0F0; @(posedge clk); #1;
    data_i = 16'h3C3C; @(posedge clk); #1;
    chk("t1_last", last_o, 1);
    data_i = 16'hFF00; @(posedge clk); #1;
    v_i = 0;
    chk("t1_v_rise", v_o, 1);
    chk("t1_ready_low", ready_o, 0);
    chk("t1_data", data_o, 16'h3000);
    @(posedge clk); #1;
    chk("t1_v_fall", v_o, 0);
    chk("t1_ready_back", ready_o, 1);
    drain("t1_drain");

    // ---------------- table vectors
    for (int i = 0; i < 7; i++) begin
      yumi_mode = (i % 2 == 0) ? 1 : 2;
      for (int k = 0; k < 4; k++) send_word(tbl[i].w[k], 16'hFFFF);
      drain("tbl_drain");
      chk($sformatf("tbl_%0d", i), last_out, tbl[i].exp);
    end
    yumi_mode = 1;

    // ---------------- hold in DONE with v_i pressure
    yumi_mode = 0;
    for (int k = 0; k < 4; k++) send_word(tbl[5].w[k], 16'hFFFF);
    v_i = 1; data_i = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_ready", ready_o, 0);
      chk("hold_v", v_o, 1);
      chk("hold_data", data_o, 16'h8001);
    end
    @(posedge clk); #1;
    v_i = 0;
    yumi_mode = 1;
    drain("hold_drain");
    chk("hold_result", last_out, 16'h8001);
    send_word(16'h5555, 16'hFFFF);
    send_word(16'hFFFF, 16'hFFFF);
    send_word(16'hFFFF, 16'hFFFF);
    send_word(16'hFFFF, 16'hFFFF);
    drain("ovw_drain");
    chk("overwrite", last_out, 16'h5555);

    // ---------------- async reset mid-group
    send_word(16'h00FF, 16'hFFFF);
    send_word(16'h0F0F, 16'hFFFF);
    @(negedge clk);
    chk("mid_cnt", dbg_cnt_o, 2);
    #2;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_v", v_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_cnt", dbg_cnt_o, 0);
    #1;
    reset_i = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) send_word(16'hAAAA, 16'hFFFF);
    drain("mid_drain");
    chk("mid_clean", last_out, 16'hAAAA);

    // ---------------- async reset while result pending
    yumi_mode = 0;
    for (int k = 0; k < 4; k++) send_word(tbl[0].w[k], 16'hFFFF);
    @(negedge clk);
    chk("done_v", v_o, 1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("done_rst_v", v_o, 0);
    chk("done_rst_ready", ready_o, 1);
    chk("done_rst_data", data_o, 0);
    #1;
    reset_i = 1'b0;
    yumi_mode = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("done_no_emit", v_o, 0);

    // ---------------- els_p = 1 instance
    v1_i = 1; d1_i = 8'h5A; yumi1_i = 0;
    chk("e1_last_a", last1_o, 1);
    chk("e1_ready_a", ready1_o, 1);
    @(posedge clk); #1;
    chk("e1_v_a", v1_o, 1);
    chk("e1_data_a", d1_o, 8'h5A);
    chk("e1_ready_b", ready1_o, 0);
    d1_i = 8'hC3; yumi1_i = 1;
    @(posedge clk); #1;
    chk("e1_bubble", v1_o, 0);
    chk("e1_ready_c", ready1_o, 1);
    chk("e1_last_b", last1_o, 1);
    yumi1_i = 0;
    @(posedge clk); #1;
    chk("e1_v_b", v1_o, 1);
    chk("e1_data_b", d1_o, 8'hC3);
    v1_i = 0; yumi1_i = 1;
    @(posedge clk); #1;
    chk("e1_v_c", v1_o, 0);
    chk("e1_last_c", last1_o, 1);
    yumi1_i = 0;

`ifdef BSG_AND_FOLD_STREAM_MASK_EN
    // ---------------- masked fold
    send_word(16'h0000, 16'h0000);
    send_word(16'h1234, 16'hFFFF);
    send_word(16'h0000, 16'h0F0F);
    send_word(16'hFFFF, 16'hFFFF);
    drain("mask_drain");
    chk("mask_result", last_out, 16'h1030);
`endif

    // ---------------- random gaps, random consumer, 1000 groups
    yumi_mode = 2;
    for (int g = 0; g < 1000; g++) begin
      for (int k = 0; k < 4; k++) begin
        send_word(16'($urandom_range(0, 16'hFFFF) | $urandom_range(0, 16'hFFFF)),
                  16'($urandom_range(0, 16'hFFFF) | 16'hF0F0));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    drain("rand_drain");

    chk("cnt_track", cnt_viol, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
